// File: rtl/key_debounce4_pkg.sv
// Shared types and constants for the four-key push-button debouncer.
package key_debounce4_pkg;

  localparam int unsigned NUM_KEYS         = 4;
  localparam int unsigned CNT_W            = 24;
  localparam int unsigned DEBOUNCE_DEFAULT = 1000000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    PRESSED   = 2'd2,
    REL_CHK   = 2'd3
  } deb_state_e;

  // Debounced level is "pressed" until a candidate release has qualified.
  function automatic logic key_down(input deb_state_e s);
    return (s == PRESSED) || (s == REL_CHK);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, stability FSM with counter,
// registered press/release pulses and an LED that toggles on every press.
module key_debounce_ch
  import key_debounce4_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic led
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             key_sync;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_state_q, key_state_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             led_q;

  // Raw key is asynchronous; idle level of the active-low button is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key};
    end
  end

  assign key_sync = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A check state commits once the counter has seen the full window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!key_sync) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else if (key_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (key_sync) begin
          state_d = REL_CHK;
          cnt_d   = '0;
        end
      end
      REL_CHK: begin
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          rel_d   = 1'b1;
        end else if (!key_sync) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    key_state_d = key_down(state_d);
  end

  // Outputs registered alongside the state so key_state tracks it exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_state_q <= 1'b0;
      press_q     <= 1'b0;
      rel_q       <= 1'b0;
      led_q       <= 1'b0;
    end else begin
      key_state_q <= key_state_d;
      press_q     <= press_d;
      rel_q       <= rel_d;
      led_q       <= led_q ^ press_q;
    end
  end

  assign key_state   = key_state_q;
  assign key_press   = press_q;
  assign key_release = rel_q;
  assign led         = led_q;

endmodule

// File: rtl/key_debounce4.sv
// Four independent push-button debounce channels driving the board LEDs.
module key_debounce4
  import key_debounce4_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] led
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .key        (key[i]),
      .key_state  (key_state[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .led        (led[i])
    );
  end

endmodule

// File: tb/tb_key_debounce4.sv
// Self-checking bench for key_debounce4: directed scenarios plus random
// bouncing, compared every cycle against a run-length reference model.
module tb_key_debounce4;

  localparam int unsigned DEB = 16;
  localparam int          LAT = DEB + 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key   = 4'hF;
  logic [3:0] key_state, key_press, key_release, led;

  always #5 clk = ~clk;

  key_debounce4 #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .led        (led)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int press_cnt[4], rel_cnt[4], press_edge[4], rel_edge[4];
  bit all_press_seen;

  // Reference model: sampled-key delay line, debounced level, run length of
  // consecutive differing samples, and a one-edge commit after a full run.
  bit         m_s1[4], m_s2[4], m_lvl[4], m_pend[4];
  int         m_run[4];
  bit [3:0]   m_press, m_rel, m_led;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_s1[i] = 1'b1; m_s2[i] = 1'b1; m_lvl[i] = 1'b0; m_pend[i] = 1'b0; m_run[i] = 0;
    end
    m_press = '0; m_rel = '0; m_led = '0;
  endfunction

  function automatic void model_edge();
    bit [3:0] np, nr;
    np = '0; nr = '0;
    for (int i = 0; i < 4; i++) begin
      if (m_pend[i]) begin
        m_lvl[i]  = !m_lvl[i];
        np[i]     = m_lvl[i];
        nr[i]     = !m_lvl[i];
        m_pend[i] = 1'b0;
        m_run[i]  = 0;
      end else if ((!m_s2[i]) != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == int'(DEB)) m_pend[i] = 1'b1;
      end else begin
        m_run[i] = 0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = key[i];
    end
    m_led   = m_led ^ m_press;
    m_press = np;
    m_rel   = nr;
  endfunction

  function automatic logic [15:0] model_out();
    logic [3:0] lv;
    for (int i = 0; i < 4; i++) lv[i] = m_lvl[i];
    return {lv, m_press, m_rel, m_led};
  endfunction

  task automatic clear_stats();
    for (int i = 0; i < 4; i++) begin
      press_cnt[i] = 0; rel_cnt[i] = 0; press_edge[i] = -1; rel_edge[i] = -1;
    end
    all_press_seen = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (key_press[i] === 1'b1)   begin press_cnt[i]++; press_edge[i] = cyc; end
      if (key_release[i] === 1'b1) begin rel_cnt[i]++;   rel_edge[i]   = cyc; end
    end
    if (key_press === 4'hF) all_press_seen = 1'b1;
    chk("outs", 32'({key_state, key_press, key_release, led}), 32'(model_out()));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_async", 32'({key_state, key_press, key_release, led}), 32'h0);
    run(2);
    rst_n = 1'b1;
    clear_stats();
  endtask

  initial begin
    int t0;
    int hold[4];
    int total;

    model_reset();
    clear_stats();
    run(2);
    chk("por_outs", 32'({key_state, key_press, key_release, led}), 32'h0);
    rst_n = 1'b1;

    // Idle after reset
    run(100);
    chk("idle_state", 32'(key_state), 32'h0);
    chk("idle_led", 32'(led), 32'h0);
    chk("idle_press", 32'(press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3]), 32'h0);

    // Clean press and release of key 0
    t0 = cyc; key[0] = 1'b0; run(40);
    chk("p0_lat", 32'(press_edge[0] - t0), 32'(LAT));
    chk("p0_cnt", 32'(press_cnt[0]), 32'd1);
    chk("p0_state", 32'(key_state), 32'h1);
    chk("p0_led", 32'(led), 32'h1);
    t0 = cyc; key[0] = 1'b1; run(40);
    chk("r0_lat", 32'(rel_edge[0] - t0), 32'(LAT));
    chk("r0_cnt", 32'(rel_cnt[0]), 32'd1);
    chk("r0_led", 32'(led), 32'h1);
    chk("r0_state", 32'(key_state), 32'h0);

    // Bouncing key 1, then a stable hold
    do_reset();
    for (int seg = 0; seg < 12; seg++) begin
      key[1] = (seg % 2 == 0) ? 1'b0 : 1'b1;
      run(5);
    end
    chk("bnc_pulses", 32'(press_cnt[1] + rel_cnt[1]), 32'h0);
    chk("bnc_state", 32'(key_state), 32'h0);
    chk("bnc_led", 32'(led), 32'h0);
    t0 = cyc; key[1] = 1'b0; run(40);
    chk("bnc_lat", 32'(press_edge[1] - t0), 32'(LAT));
    chk("bnc_cnt", 32'(press_cnt[1]), 32'd1);
    chk("bnc_led2", 32'(led), 32'h2);
    key = 4'hF; run(40);

    // All keys pressed on the same edge
    do_reset();
    key = 4'h0; run(40);
    chk("sim_same_cycle", 32'(all_press_seen), 32'h1);
    chk("sim_led", 32'(led), 32'hF);
    chk("sim_state", 32'(key_state), 32'hF);
    key = 4'hF; run(40);
    chk("sim_rel_led", 32'(led), 32'hF);
    chk("sim_rel_cnt", 32'(rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3]), 32'd4);
    key[2] = 1'b0; run(40); key[2] = 1'b1; run(40);
    chk("k2_led", 32'(led), 32'hB);
    chk("k2_cnt", 32'(press_cnt[2]), 32'd2);

    // Reset in the middle of a qualification and while another key is held
    do_reset();
    key[0] = 1'b0; run(40);
    chk("mid_pre_led", 32'(led), 32'h1);
    key[3] = 1'b0; run(11);
    do_reset();
    t0 = cyc - 2;
    t0 = cyc;
    run(40);
    chk("mid_p3_lat", 32'(press_edge[3] - t0), 32'(LAT));
    chk("mid_p0_lat", 32'(press_edge[0] - t0), 32'(LAT));
    chk("mid_cnt", 32'(press_cnt[3] + press_cnt[0]), 32'd2);
    chk("mid_led", 32'(led), 32'h9);
    key = 4'hF; run(40);

    // Near-miss glitch one cycle short of the window, then exactly the window
    do_reset();
    key[0] = 1'b0; run(15); key[0] = 1'b1; run(40);
    chk("nm15_cnt", 32'(press_cnt[0]), 32'd0);
    chk("nm15_led", 32'(led), 32'h0);
    key[0] = 1'b0; run(16); key[0] = 1'b1; run(40);
    chk("nm16_cnt", 32'(press_cnt[0]), 32'd1);
    chk("nm16_rel", 32'(rel_cnt[0]), 32'd1);
    chk("nm16_led", 32'(led), 32'h1);

    // Random bouncing on all keys, with one reset in the middle
    do_reset();
    total = 0;
    for (int i = 0; i < 4; i++) hold[i] = $urandom_range(1, 40);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          key[i]  = ~key[i];
          hold[i] = $urandom_range(1, 40);
        end
        hold[i]--;
      end
      if (c == 1500) begin
        for (int i = 0; i < 4; i++) total += press_cnt[i];
        do_reset();
      end
      step();
    end
    for (int i = 0; i < 4; i++) total += press_cnt[i];
    chk("rnd_activity", 32'(total > 0), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/key_debounce4.md
KEY_DEBOUNCE4 -- requirements
Module: key_debounce4

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000 (20 ms at 50 MHz), legal range 2..2^24-1, giving the required stable-level time in clk cycles.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port key, input, 4 bits: raw board push-buttons, active-low (0 = pressed), asynchronous to clk.
REQ-005 The block SHALL have port key_state, output, 4 bits: debounced level per key (1 = pressed).
REQ-006 The block SHALL have port key_press, output, 4 bits: one-cycle pulse per key on a debounced press.
REQ-007 The block SHALL have port key_release, output, 4 bits: one-cycle pulse per key on a debounced release.
REQ-008 The block SHALL have port led, output, 4 bits: per-key toggle register that drives the board LEDs directly.

Function
REQ-009 Each key bit SHALL pass through a 2-flop synchronizer before any other use; both flops hold 1 (released).
REQ-010 Each key SHALL have an independent 4-state FSM.
 - IDLE: stable released.
 - PRESS_CHK: candidate press.
 - PRESSED: stable pressed.
 - REL_CHK: candidate release.
REQ-011 IDLE SHALL go to PRESS_CHK when the synced key is 0; PRESSED SHALL go to REL_CHK when the synced key is 1; the counter SHALL be cleared on each such entry.
REQ-012 In PRESS_CHK or REL_CHK, a synced level back at the old value SHALL return the FSM to IDLE or PRESSED respectively, clear the counter and emit no pulse.
REQ-013 In PRESS_CHK or REL_CHK, the counter SHALL increment each cycle the new level holds; at count DEBOUNCE_CYCLES-1 the FSM SHALL go to PRESSED or IDLE respectively on the next edge.
REQ-014 The counter SHALL be 24 bits, SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-015 key_state[i] SHALL be 1 exactly while FSM i is in PRESSED or REL_CHK.
REQ-016 key_press[i] SHALL be high for exactly the one cycle in which FSM i enters PRESSED from PRESS_CHK, and SHALL be registered.
REQ-017 key_release[i] SHALL be high for exactly the one cycle in which FSM i enters IDLE from REL_CHK, and SHALL be registered.
REQ-018 led[i] SHALL invert on the edge following each key_press[i] pulse; releases SHALL not affect led.
REQ-019 Latency SHALL be fixed at DEBOUNCE_CYCLES+3 clk edges.
 - Measured from the first edge sampling a stable new raw level.
 - Ends at the edge asserting key_press or key_release.
REQ-020 Keys SHALL be fully independent; simultaneous events on several keys SHALL produce pulses on those bits in the same cycle.
REQ-021 Glitches shorter than DEBOUNCE_CYCLES synced cycles SHALL produce no state change, pulse or LED change.
REQ-022 A held key SHALL yield exactly one key_press, with no auto-repeat.

Reset
REQ-023 On rst_n low, the block SHALL immediately set:
 - FSMs = IDLE, counters = 0, synchronizers = 1;
 - key_state = 0, key_press = 0, key_release = 0, led = 4'b0000.
REQ-024 Reset asserted mid-debounce or while pressed SHALL abort with no pulse; after release, a key still held SHALL re-qualify as a fresh press from IDLE.
REQ-025 Reset deassertion SHALL need no synchronization inside this block; the top level supplies a deassert-synchronized rst_n.

Structure
REQ-026 The shared package/header SHALL hold:
 - the FSM state encodings (2-bit: IDLE=0, PRESS_CHK=1, PRESSED=2, REL_CHK=3);
 - the counter width constant (24);
 - the default DEBOUNCE_CYCLES.
REQ-027 One sub-module, key_debounce_ch, SHALL implement the synchronizer, FSM, counter, pulses and LED toggle for one key; key_debounce4 SHALL instantiate it four times.

Verification (bench uses DEBOUNCE_CYCLES=16)
REQ-028 Reset then idle: key=4'hF for 100 cycles -> all outputs 0, led=4'b0000.
REQ-029 Clean press: key[0]=0 held 40 cycles -> one key_press=4'b0001 pulse 19 edges after first low sample, key_state[0]=1, led=4'b0001; then release -> one key_release=4'b0001 pulse 19 edges later, led unchanged.
REQ-030 Bounce: key[1] toggled every 5 cycles for 60 cycles, then held 0 -> no output change during bouncing; exactly one key_press[1] 19 edges after the last bounce.
REQ-031 Simultaneous: key 4'hF->4'h0 on one edge and held -> key_press=4'hF in a single cycle, led=4'hF; a second press/release of key[2] -> led=4'b1011.
REQ-032 Reset mid-operation: key[3] pressed, rst_n pulsed low at count 8 -> outputs 0 at once; key held after reset -> key_press[3] 19 edges after rst_n release.
REQ-033 Near-miss glitch: key[0] low for exactly 15 synced cycles -> no pulse; held for 16 -> pulse.
